// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequencer for one serial scan chain.
// Each accepted START shifts a parallel pattern into the chain (MSB first),
// collects the old chain contents from SO into UNLOAD_DATA, then gives the
// chain one functional capture clock with SE low before pulsing DONE.
//
// Handshake: START is a level sampled only while idle; it is accepted on the
// edge where it is high in IDLE, BUSY rises after that edge, and DONE pulses
// for exactly one cycle once the capture edge has happened. ABORT drops any
// operation in progress at the edge it is sampled, with no DONE.
module scan_chain_ctrl #(
  parameter  int CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] LOAD_DATA,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] UNLOAD_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CHAIN_LEN-1:0] pattern_nxt;
  logic                 se_nxt;
  logic                 si_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 unload_we;
  logic [CNT_W-1:0]     unload_idx;
  logic                 last_shift;

  // cnt counts completed shifts; shift k writes SO into bit N-1-k.
  assign last_shift = (cnt == LAST_SHIFT);
  assign unload_idx = LAST_SHIFT - cnt;

  // Next-state and next-output logic; SE/SI/BUSY/DONE are computed here and
  // registered below so they leave the block straight from flops.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    se_nxt      = 1'b0;
    si_nxt      = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    unload_we   = 1'b0;

    if (ABORT) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state_nxt   = ST_SHIFT;
            cnt_nxt     = '0;
            pattern_nxt = LOAD_DATA;
            se_nxt      = 1'b1;
            si_nxt      = LOAD_DATA[CHAIN_LEN-1];
            busy_nxt    = 1'b1;
          end
        end

        ST_SHIFT: begin
          // The pattern rotates so the bit for the next shift is always at
          // CHAIN_LEN-2; after N shifts it is back in its original order.
          unload_we   = 1'b1;
          cnt_nxt     = cnt + CNT_W'(1);
          pattern_nxt = {pattern[CHAIN_LEN-2:0], pattern[CHAIN_LEN-1]};
          busy_nxt    = 1'b1;
          if (last_shift) begin
            state_nxt = ST_CAPTURE;
          end else begin
            se_nxt = 1'b1;
            si_nxt = pattern[CHAIN_LEN-2];
          end
        end

        ST_CAPTURE: begin
          // SE is already low this cycle, so this edge is the capture clock.
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end

        ST_DONE: begin
          // START is deliberately not looked at here.
          state_nxt = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter, pattern and registered chain-facing outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pattern <= '0;
      SE      <= 1'b0;
      SI      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pattern <= pattern_nxt;
      SE      <= se_nxt;
      SI      <= si_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
    end
  end

  // Unload register: one bit per shift edge, untouched otherwise so partial
  // results survive an ABORT and the full result stays put after DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      UNLOAD_DATA <= '0;
    end else begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (unload_we && (unload_idx == CNT_W'(i))) begin
          UNLOAD_DATA[i] <= SO;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-cell behavioural scan chain.
// Directed operations push their expected result (DONE cycle, shifted
// pattern, unloaded data) into exp_q; a monitor pops one entry per DONE.
module tb_scan_chain_ctrl;

  localparam int N  = 4;
  localparam int EW = 32 + 2 * N;

  // ---------------------------------------------------------------- clock/reset
  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         ABORT;
  logic [N-1:0] LOAD_DATA;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] UNLOAD_DATA;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .ABORT       (ABORT),
    .LOAD_DATA   (LOAD_DATA),
    .SO          (SO),
    .SE          (SE),
    .SI          (SI),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .UNLOAD_DATA (UNLOAD_DATA)
  );

  // Behavioural chain: shift when SE, otherwise capture functional D.
  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;
  always @(posedge CLK) begin
    if (SE) chain_q <= {chain_q[N-2:0], SI};
    else    chain_q <= chain_d;
  end
  assign SO = chain_q[N-1];

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int done_cyc, input logic [N-1:0] pat, input logic [N-1:0] unl);
    exp_q.push_back({32'(done_cyc), pat, unl});
  endtask

  // Monitor: SI bits seen while SE is high are collected MSB-first, so after a
  // full operation they must equal the accepted LOAD_DATA.
  logic [N-1:0]  si_seq = '0;
  int            se_cnt = 0;
  logic [EW-1:0] e;
  always @(negedge CLK) begin
    if (RST) begin
      se_cnt = 0;
    end else begin
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(DONE), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), e[EW-1 -: 32]);
          check("si_seq", 32'(si_seq), 32'(e[2*N-1 -: N]));
          check("unload", 32'(UNLOAD_DATA), 32'(e[N-1:0]));
          check("se_cycles", 32'(se_cnt), 32'(N));
        end
      end
      if (!BUSY) begin
        check("se_low_idle", 32'(SE), 32'(0));
        se_cnt = 0;
      end else if (SE) begin
        si_seq = {si_seq[N-2:0], SI};
        se_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int c;
  initial begin
    RST = 1'b1; START = 1'b1; ABORT = 1'b0; LOAD_DATA = 4'b1111; chain_d = '0;

    // Reset held two cycles with START high.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_se", 32'(SE), 32'(0));
    check("rst_si", 32'(SI), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_done", 32'(DONE), 32'(0));
    check("rst_unload", 32'(UNLOAD_DATA), 32'(0));
    RST = 1'b0; START = 1'b0;
    tick();
    check("post_rst_idle", 32'(BUSY), 32'(0));

    // Basic pattern: chain 1010, load 0110, functional D 1111.
    chain_d = 4'b1010;
    tick(); tick();
    c = cyc;
    push_exp(c + N + 2, 4'b0110, 4'b1010);
    START = 1'b1; LOAD_DATA = 4'b0110;
    tick();
    START = 1'b0; LOAD_DATA = 4'b1001; chain_d = 4'b1111;
    check("basic_busy", 32'(BUSY), 32'(1));
    check("basic_se", 32'(SE), 32'(1));
    check("basic_si0", 32'(SI), 32'(0));
    repeat (N) tick();
    check("basic_cap_se", 32'(SE), 32'(0));
    check("basic_cap_busy", 32'(BUSY), 32'(1));
    check("basic_chain_pre", 32'(chain_q), 32'(4'b0110));
    tick();
    check("basic_done", 32'(DONE), 32'(1));
    check("basic_done_busy", 32'(BUSY), 32'(0));
    check("basic_chain_post", 32'(chain_q), 32'(4'b1111));
    tick();
    check("basic_done_pulse", 32'(DONE), 32'(0));

    // Back-to-back with START held: second op accepted at edge t+7.
    chain_d = 4'b0011;
    tick();
    c = cyc;
    push_exp(c + N + 2, 4'b0001, 4'b0011);
    push_exp(c + 2 * N + 5, 4'b1000, 4'b1100);
    START = 1'b1; LOAD_DATA = 4'b0001;
    tick();
    LOAD_DATA = 4'b1000; chain_d = 4'b1100;
    repeat (N + 1) tick();
    check("b2b_done1", 32'(DONE), 32'(1));
    tick();
    check("b2b_idle_busy", 32'(BUSY), 32'(0));
    check("b2b_idle_se", 32'(SE), 32'(0));
    tick();
    START = 1'b0;
    check("b2b_restart_busy", 32'(BUSY), 32'(1));
    check("b2b_restart_si", 32'(SI), 32'(1));
    repeat (N + 1) tick();
    check("b2b_done2", 32'(DONE), 32'(1));
    tick();

    // START pulsed at shift k=2 with other data is ignored.
    chain_d = 4'b0101;
    tick();
    c = cyc;
    push_exp(c + N + 2, 4'b1101, 4'b0101);
    START = 1'b1; LOAD_DATA = 4'b1101;
    tick();
    START = 1'b0; LOAD_DATA = 4'b0010;
    tick(); tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    check("busy_start_done", 32'(DONE), 32'(1));
    repeat (8) tick();

    // ABORT at shift k=2, then a clean operation.
    START = 1'b1; LOAD_DATA = 4'b0011;
    tick();
    START = 1'b0;
    tick(); tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_se", 32'(SE), 32'(0));
    check("abort_si", 32'(SI), 32'(0));
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_done", 32'(DONE), 32'(0));
    check("abort_partial", 32'(UNLOAD_DATA[3:2]), 32'(2'b01));
    repeat (3) tick();
    check("abort_stays_idle", 32'(BUSY), 32'(0));
    chain_d = 4'b0110;
    tick();
    c = cyc;
    push_exp(c + N + 2, 4'b1110, 4'b0110);
    START = 1'b1; LOAD_DATA = 4'b1110;
    tick();
    START = 1'b0;
    repeat (N + 1) tick();
    check("after_abort_done", 32'(DONE), 32'(1));
    tick();

    // RST during CAPTURE.
    START = 1'b1; LOAD_DATA = 4'b1011;
    tick();
    START = 1'b0;
    repeat (N) tick();
    check("rstcap_se", 32'(SE), 32'(0));
    check("rstcap_busy", 32'(BUSY), 32'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstcap_se_after", 32'(SE), 32'(0));
    check("rstcap_si_after", 32'(SI), 32'(0));
    check("rstcap_busy_after", 32'(BUSY), 32'(0));
    check("rstcap_done_after", 32'(DONE), 32'(0));
    check("rstcap_unload_after", 32'(UNLOAD_DATA), 32'(0));
    repeat (6) tick();

    // Every expected DONE must have been seen.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
